pc_sequencer: RTL
=================

# pc_sequencer

Fetch-address sequencer for the RISC core. It owns the program counter and steps it sequentially. It applies redirects produced by the branch unit: conditional, jump, call and return. It keeps a hardware return-address stack so calls and returns resolve without a register-file round trip. It sits between the branch unit (execute stage) and instruction memory, and drives a flush to the fetch/decode pipeline registers.

## Interface
Parameters:
- PC_W, 11, width of the fetch address
- RAS_DEPTH, 8, return-stack entries (power of two, ≥2)
- FLUSH_CYCLES, 1, bubble cycles after a redirect (≥1)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_ready  in  1  instruction memory accepts pc this cycle
- halt  in  1  stop fetching while high
- br_valid  in  1  one-cycle pulse: branch unit result valid
- br_kind  in  2  00 cond, 01 jump, 10 call, 11 return
- br_taken  in  1  branch condition result (cond only)
- br_target  in  PC_W  target; for return, fallback register value
- br_link  in  PC_W  return address pushed on call
- pc  out  PC_W  current fetch address
- fetch_valid  out  1  pc is a valid fetch request
- flush  out  1  kill in-flight fetch/decode entries
- ras_overflow  out  1  sticky: push onto full stack
- ras_underflow  out  1  sticky: pop from empty stack

## Operation
- States: IDLE, FETCH, FLUSH, HALTED.
- Reset (async): state IDLE, pc 0, fetch_valid 0, flush 0, both sticky flags 0, stack empty, flush counter 0.
- IDLE: next cycle goes to FETCH; fetch_valid is 1 from FETCH onward.
- FETCH, no redirect:
  - fetch_ready=1: pc <= pc+1, modulo 2^PC_W, so all-ones wraps to 0.
  - fetch_ready=0: pc holds.
- Redirect condition: br_valid=1, and either br_kind≠cond or br_taken=1. br_taken is ignored for jump, call and return.
- Redirect target:
  - cond/jump: br_target.
  - call: br_target; push br_link.
  - return: pop top of stack. If the stack is empty, use br_target and set ras_underflow.
- Call on a full stack: overwrite the oldest entry (circular) and set ras_overflow; depth stays RAS_DEPTH.
- On redirect: pc <= target, flush <= 1 for exactly one cycle, state FLUSH.
- FLUSH: fetch_valid 0 and pc holds for FLUSH_CYCLES cycles. Then go to HALTED if halt=1, else FETCH.
- br_valid while in FLUSH or IDLE: ignored. No stack change, no flag change.
- HALTED:
  - Entered from FETCH when halt=1 and there is no redirect.
  - fetch_valid 0, pc holds; returns to FETCH the cycle after halt=0.
  - A redirect in HALTED is applied as in FETCH.
- Priority within a cycle: redirect > halt > sequential increment.
- Sticky flags clear only on reset.

## Timing
- Redirect latency: br_valid high at edge N, then at N+1 pc=target and flush=1, fetch_valid=0.
- After a redirect, fetch_valid rises at N+1+FLUSH_CYCLES.
- Stack push/pop commit at the same edge as the pc update. A call at N followed by a return at N+1+FLUSH_CYCLES or later returns br_link of that call.
- halt asserted at edge N in FETCH: fetch_valid=0 at N+1.
- halt deasserted at edge M: fetch_valid=1 at M+1, with pc unchanged.
- Reset asserted mid-FLUSH or mid-HALTED: all outputs take their reset values immediately (async); the stack is emptied.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package pc_seq_pkg holds:
  - br_kind encodings (BR_COND, BR_JUMP, BR_CALL, BR_RET).
  - State enum.
  - Default PC_W.
- Sub-module return_stack (RAS_DEPTH × PC_W): push, pop, top, empty, full, circular overwrite on full. Its reset is the same async active-low rst_n.
- Top level holds the FSM, pc register, flush counter and sticky flags.

## Test plan
- Reset release with fetch_ready=1 held → pc reads 0,1,2,3…, fetch_valid rises one cycle after IDLE; pc=0x7FF wraps to 0x000.
- Cond br_valid, br_taken=0, target 0x100 → no flush, pc keeps incrementing. Repeat with br_taken=1 → pc=0x100 and flush=1 next cycle, fetch_valid low for FLUSH_CYCLES.
- Call target 0x200 link 0x011, later return with br_target 0x3FF → pc=0x011 after the return; ras_underflow stays 0.
- Nine calls (links 1..9) then nine returns with RAS_DEPTH=8 → returns yield 9,8,…,2, then the ninth uses br_target; ras_overflow=1 and ras_underflow=1.
- halt and a taken jump to 0x050 in the same cycle → pc=0x050, FLUSH, then HALTED. Releasing halt → fetch resumes at 0x050.
- rst_n low mid-FLUSH after a call → pc=0, flush=0, flags 0. A subsequent return with empty stack takes br_target and sets ras_underflow.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-address sequencer: branch-kind encodings,
// FSM state encoding and the default fetch-address width.
package pc_seq_pkg;

    localparam int PC_W_DEFAULT = 11;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JUMP = 2'b01,
        BR_CALL = 2'b10,
        BR_RET  = 2'b11
    } br_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_HALTED = 2'b11
    } seq_state_e;

endpackage

// File: rtl/return_stack.sv
// Circular hardware return-address stack. A push onto a full stack
// overwrites the oldest entry; a pop from an empty stack is ignored.
module return_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_empty,
    output logic             o_full
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0] r_wp;
    logic [IDX_W:0]   r_count;
    logic [IDX_W-1:0] w_top_idx;

    // r_wp is the next free slot; when full it also points at the oldest
    // entry, so a plain write there gives the circular overwrite.
    assign w_top_idx = r_wp - IDX_W'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (IDX_W+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_wp <= r_wp + IDX_W'(1);
            if (!o_full) begin
                r_count <= r_count + (IDX_W+1)'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_wp    <= r_wp - IDX_W'(1);
            r_count <= r_count - (IDX_W+1)'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: owns the program counter, applies branch-unit
// redirects (with a return-address stack for call/return) and drives flush.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W         = PC_W_DEFAULT,
    parameter int RAS_DEPTH    = 8,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_ready,
    input  logic            halt,
    input  logic            br_valid,
    input  logic [1:0]      br_kind,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] br_link,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            flush,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    seq_state_e       r_state;
    seq_state_e       w_state_next;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_fetch_valid;
    logic             r_flush;
    logic             r_ovf;
    logic             r_unf;

    logic             w_active;
    logic             w_redirect;
    logic             w_is_call;
    logic             w_is_ret;
    logic             w_ras_empty;
    logic             w_ras_full;
    logic [PC_W-1:0]  w_ras_top;
    logic [PC_W-1:0]  w_target;

    // Branch results only count while fetching or halted; IDLE/FLUSH drop them.
    assign w_active   = (r_state == ST_FETCH) || (r_state == ST_HALTED);
    assign w_redirect = w_active && br_valid &&
                        ((br_kind != BR_COND) || br_taken);
    assign w_is_call  = w_redirect && (br_kind == BR_CALL);
    assign w_is_ret   = w_redirect && (br_kind == BR_RET);
    assign w_target   = (w_is_ret && !w_ras_empty) ? w_ras_top : br_target;

    return_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (PC_W)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_is_call),
        .i_pop   (w_is_ret),
        .i_data  (br_link),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (w_ras_full)
    );

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cnt_next   = r_cnt;
        if (w_redirect) begin
            w_state_next = ST_FLUSH;
            w_pc_next    = w_target;
            w_cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_FETCH;
                end
                ST_FETCH: begin
                    if (halt) begin
                        w_state_next = ST_HALTED;
                    end else if (fetch_ready) begin
                        w_pc_next = r_pc + PC_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (r_cnt == '0) begin
                        w_state_next = halt ? ST_HALTED : ST_FETCH;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    if (!halt) begin
                        w_state_next = ST_FETCH;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_cnt         <= '0;
            r_fetch_valid <= 1'b0;
            r_flush       <= 1'b0;
            r_ovf         <= 1'b0;
            r_unf         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_cnt         <= w_cnt_next;
            r_fetch_valid <= (w_state_next == ST_FETCH);
            r_flush       <= w_redirect;
            if (w_is_call && w_ras_full) begin
                r_ovf <= 1'b1;
            end
            if (w_is_ret && w_ras_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign pc            = r_pc;
    assign fetch_valid   = r_fetch_valid;
    assign flush         = r_flush;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule
